// File: rtl/pc_sequencer_if.sv
// Handshake and control bundle between the PDP-8 style major-state sequencer
// and its datapath/memory. The sequencer uses the master modport.
interface pc_sequencer_if;
    logic       RUN;
    logic [2:0] OPCODE;
    logic       IND;
    logic       SKIP;
    logic       ZERO;
    logic       MEM_ACK;
    logic       MEM_REQ;
    logic       MEM_WE;
    logic [1:0] ADDR_SEL;
    logic       IR_LOAD;
    logic       EA_LOAD;
    logic       PC_STEP;
    logic       PC_LD;
    logic       PC_LATCH;
    logic [3:0] STATE;
    logic       HALTED;
    logic       ERR;

    modport master (
        input  RUN, OPCODE, IND, SKIP, ZERO, MEM_ACK,
        output MEM_REQ, MEM_WE, ADDR_SEL, IR_LOAD, EA_LOAD, PC_STEP, PC_LD,
               PC_LATCH, STATE, HALTED, ERR
    );

    modport slave (
        output RUN, OPCODE, IND, SKIP, ZERO, MEM_ACK,
        input  MEM_REQ, MEM_WE, ADDR_SEL, IR_LOAD, EA_LOAD, PC_STEP, PC_LD,
               PC_LATCH, STATE, HALTED, ERR
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/defer/execute/write-back major-state sequencer with memory-timeout fault.
// Strobes tied to MEM_ACK fire in the acknowledge cycle itself, so outputs decode from state.
module pc_sequencer #(
    parameter int TIMEOUT = 15
) (
    input logic            CLK,
    input logic            RESET,
    pc_sequencer_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        HALT    = 4'd0,
        F_REQ   = 4'd1,
        F_WAIT  = 4'd2,
        DECODE  = 4'd3,
        D_REQ   = 4'd4,
        D_WAIT  = 4'd5,
        E_REQ   = 4'd6,
        E_WAIT  = 4'd7,
        WB_REQ  = 4'd8,
        WB_WAIT = 4'd9,
        EXEC    = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t        state_q;
    logic          err_q;
    logic [1:0]    jumpSel_q;
    logic [CW-1:0] waitCnt_q;

    logic   isWait;
    logic   ack;
    logic   timeout;
    state_t doneState;

    assign isWait    = state_q inside {F_WAIT, D_WAIT, E_WAIT, WB_WAIT};
    assign ack       = isWait & bus.MEM_ACK;
    assign timeout   = isWait & ~bus.MEM_ACK & (waitCnt_q == CW'(TIMEOUT - 1));
    assign doneState = bus.RUN ? F_REQ : HALT;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= HALT;
            err_q     <= 1'b0;
            jumpSel_q <= 2'b00;
            waitCnt_q <= '0;
        end else begin
            // Counter only runs while a wait state is stalled; every other cycle rearms it.
            waitCnt_q <= '0;
            if (timeout) begin
                err_q   <= 1'b1;
                state_q <= HALT;
            end else begin
                case (state_q)
                    HALT:    if (bus.RUN && !err_q) state_q <= F_REQ;
                    F_REQ:   state_q <= F_WAIT;
                    F_WAIT:  if (ack) state_q <= DECODE;
                             else waitCnt_q <= waitCnt_q + CW'(1);
                    DECODE: begin
                        if (bus.OPCODE[2:1] == 2'b11) begin
                            state_q <= EXEC;
                        end else if (bus.IND) begin
                            state_q <= D_REQ;
                        end else if (bus.OPCODE == 3'd5) begin
                            state_q   <= JUMP;
                            jumpSel_q <= 2'b01;
                        end else begin
                            state_q <= E_REQ;
                        end
                    end
                    D_REQ:   state_q <= D_WAIT;
                    D_WAIT: begin
                        if (!ack) begin
                            waitCnt_q <= waitCnt_q + CW'(1);
                        end else if (bus.OPCODE == 3'd5) begin
                            state_q   <= JUMP;
                            jumpSel_q <= 2'b10;
                        end else begin
                            state_q <= E_REQ;
                        end
                    end
                    E_REQ:   state_q <= E_WAIT;
                    E_WAIT: begin
                        if (!ack) begin
                            waitCnt_q <= waitCnt_q + CW'(1);
                        end else if (bus.OPCODE == 3'd2) begin
                            state_q <= WB_REQ;
                        end else if (bus.OPCODE == 3'd4) begin
                            state_q   <= JUMP;
                            jumpSel_q <= 2'b11;
                        end else begin
                            state_q <= doneState;
                        end
                    end
                    WB_REQ:  state_q <= WB_WAIT;
                    WB_WAIT: if (ack) state_q <= doneState;
                             else waitCnt_q <= waitCnt_q + CW'(1);
                    EXEC:    state_q <= doneState;
                    JUMP:    state_q <= doneState;
                    default: state_q <= HALT;
                endcase
            end
        end
    end

    always_comb begin
        bus.MEM_REQ  = 1'b0;
        bus.MEM_WE   = 1'b0;
        bus.ADDR_SEL = 2'b00;
        bus.IR_LOAD  = 1'b0;
        bus.EA_LOAD  = 1'b0;
        bus.PC_STEP  = 1'b0;
        bus.PC_LD    = 1'b0;
        bus.PC_LATCH = 1'b0;
        case (state_q)
            F_REQ: begin
                bus.MEM_REQ  = 1'b1;
                bus.PC_LATCH = 1'b1;
            end
            F_WAIT: begin
                bus.MEM_REQ = 1'b1;
                bus.IR_LOAD = ack;
                bus.PC_STEP = ack;
            end
            D_REQ, D_WAIT: begin
                bus.MEM_REQ  = 1'b1;
                bus.ADDR_SEL = 2'b01;
                bus.EA_LOAD  = ack;
            end
            E_REQ, E_WAIT: begin
                bus.MEM_REQ  = 1'b1;
                bus.ADDR_SEL = 2'b01;
                bus.MEM_WE   = (bus.OPCODE == 3'd3) || (bus.OPCODE == 3'd4);
            end
            WB_REQ, WB_WAIT: begin
                bus.MEM_REQ  = 1'b1;
                bus.MEM_WE   = 1'b1;
                bus.ADDR_SEL = 2'b01;
                bus.PC_STEP  = ack & bus.ZERO;
            end
            EXEC:    bus.PC_STEP = bus.SKIP;
            JUMP: begin
                bus.PC_LD    = 1'b1;
                bus.ADDR_SEL = jumpSel_q;
            end
            default: ;
        endcase
    end

    assign bus.STATE  = state_q;
    assign bus.HALTED = (state_q == HALT);
    assign bus.ERR    = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: instruction flows, skip/ISZ stepping,
// RUN drop, asynchronous reset mid-handshake and memory timeout.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.TIMEOUT(15)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic run, input logic [2:0] op, input logic ind,
                                 input logic skip, input logic zero);
        bus.RUN    = run;
        bus.OPCODE = op;
        bus.IND    = ind;
        bus.SKIP   = skip;
        bus.ZERO   = zero;
    endtask

    // Inputs change 2 time units after the rising edge; ACK is a one-edge pulse.
    task automatic nextCycle();
        @(posedge clk);
        #2;
        bus.MEM_ACK = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] st, input logic req,
                               input logic we, input logic [1:0] sel, input logic ir,
                               input logic ea, input logic step, input logic ld,
                               input logic latch, input logic err);
        logic [14:0] observed;
        logic [14:0] expected;
        #1;
        expected = {req, we, sel, ir, ea, step, ld, latch, (st == 4'd0), err, st};
        observed = {bus.MEM_REQ, bus.MEM_WE, bus.ADDR_SEL, bus.IR_LOAD, bus.EA_LOAD,
                    bus.PC_STEP, bus.PC_LD, bus.PC_LATCH, bus.HALTED, bus.ERR, bus.STATE};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One request/wait handshake: REQ cycle, 'waits' stalled cycles, then the ACK cycle.
    task automatic memCycle(input string tag, input logic [3:0] reqSt, input logic [1:0] sel,
                            input logic we, input logic latch, input int waits,
                            input logic ir, input logic ea, input logic step);
        checkOutput({tag, "_req"}, reqSt, 1'b1, we, sel, 1'b0, 1'b0, 1'b0, 1'b0, latch, 1'b0);
        nextCycle();
        for (int i = 0; i < waits; i++) begin
            checkOutput({tag, "_wait"}, reqSt + 4'd1, 1'b1, we, sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            nextCycle();
        end
        bus.MEM_ACK = 1'b1;
        checkOutput({tag, "_ack"}, reqSt + 4'd1, 1'b1, we, sel, ir, ea, step, 1'b0, 1'b0, 1'b0);
        nextCycle();
    endtask

    task automatic fetchDecode(input string tag);
        memCycle({tag, "_fetch"}, 4'd1, 2'b00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        checkOutput({tag, "_decode"}, 4'd3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();
    endtask

    initial begin
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        bus.MEM_ACK = 1'b0;
        reset = 1'b1;
        checkOutput("reset", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("reset_hold", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("post_reset", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // TAD direct, two stalled cycles per handshake, stray ACK in DECODE
        memCycle("tad_fetch", 4'd1, 2'b00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1);
        bus.MEM_ACK = 1'b1;
        checkOutput("tad_decode_stray_ack", 4'd3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();
        memCycle("tad_exec", 4'd6, 2'b01, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        fetchDecode("jmpi");
        memCycle("jmpi_defer", 4'd4, 2'b01, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        checkOutput("jmpi_jump", 4'd11, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0);
        nextCycle();

        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        fetchDecode("jms");
        memCycle("jms_store", 4'd6, 2'b01, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        checkOutput("jms_jump", 4'd11, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0);
        nextCycle();

        applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        fetchDecode("jmp");
        checkOutput("jmp_jump", 4'd11, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        nextCycle();

        applyStimulus(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
        fetchDecode("opr_skip");
        checkOutput("opr_skip_exec", 4'd10, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        nextCycle();

        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        fetchDecode("iot_noskip");
        checkOutput("iot_noskip_exec", 4'd10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();

        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        fetchDecode("isz0");
        memCycle("isz0_read", 4'd6, 2'b01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        memCycle("isz0_wb", 4'd8, 2'b01, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        fetchDecode("isz1");
        memCycle("isz1_read", 4'd6, 2'b01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        memCycle("isz1_wb", 4'd8, 2'b01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        fetchDecode("tadi");
        memCycle("tadi_defer", 4'd4, 2'b01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        memCycle("tadi_exec", 4'd6, 2'b01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // DCA with RUN dropped mid-instruction: the store completes, then HALT
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        memCycle("dca_fetch", 4'd1, 2'b00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("dca_decode", 4'd3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();
        memCycle("dca_store", 4'd6, 2'b01, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        checkOutput("dca_halt", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("halt_stays", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while E_WAIT holds MEM_REQ
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        fetchDecode("rst");
        checkOutput("rst_ereq", 4'd6, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("rst_ewait", 4'd7, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        checkOutput("rst_async", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_release", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // ACK withheld for 15 wait cycles in F_WAIT
        checkOutput("to_freq", 4'd1, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        nextCycle();
        for (int i = 0; i < 15; i++) begin
            checkOutput("to_fwait", 4'd2, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
            nextCycle();
        end
        checkOutput("to_err", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            bus.MEM_ACK = 1'b1;
            nextCycle();
            checkOutput("to_stuck", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        end
        reset = 1'b1;
        checkOutput("to_reset_clears", 4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
